mem_access_unit: RTL and testbench

//  MEM-stage load/store engine. Consumes the EX/MEM register outputs (ALU result as address, rs2 data, dest reg, inst_name)
//  and runs a req/ack transaction with data memory: byte-lane steering, load sign/zero extension, bus timeout.

---
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with byte-lane steering, load extension and bus timeout.
// Build option MEM_ALIGN_EXC_EN: misaligned halfword/word accesses raise addr_exc instead of a request.
module mem_access_unit #(
  parameter logic [7:0]  OP_LB   = 8'd20,
  parameter logic [7:0]  OP_LBU  = 8'd21,
  parameter logic [7:0]  OP_LH   = 8'd22,
  parameter logic [7:0]  OP_LHU  = 8'd23,
  parameter logic [7:0]  OP_LW   = 8'd24,
  parameter logic [7:0]  OP_SB   = 8'd25,
  parameter logic [7:0]  OP_SH   = 8'd26,
  parameter logic [7:0]  OP_SW   = 8'd27,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [7:0]  inst_name,
  input  logic [31:0] aluResult,
  input  logic [31:0] readData2,
  input  logic [4:0]  writeDataReg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        addr_exc,
  output logic [31:0] bad_vaddr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_q;
  logic [1:0]       off_q;
  logic [4:0]       reg_q;
  logic             flushed_q;

  logic        is_load_c;
  logic        is_store_c;
  logic        is_mem_c;
  logic        accept_c;
  logic        align_fault_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign stall    = (state == BUSY);
  assign accept_c = (state == IDLE) && in_valid && !flush;

  // Opcode decode and lane steering for the slot being offered
  always_comb begin
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    be_c       = 4'b0000;
    wdata_c    = 32'h0;
    case (inst_name)
      OP_LB, OP_LBU: begin
        is_load_c = 1'b1;
        be_c      = 4'b0001 << aluResult[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load_c = 1'b1;
        be_c      = aluResult[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        is_load_c = 1'b1;
        be_c      = 4'b1111;
      end
      OP_SB: begin
        is_store_c = 1'b1;
        be_c       = 4'b0001 << aluResult[1:0];
        wdata_c    = {4{readData2[7:0]}};
      end
      OP_SH: begin
        is_store_c = 1'b1;
        be_c       = aluResult[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{readData2[15:0]}};
      end
      OP_SW: begin
        is_store_c = 1'b1;
        be_c       = 4'b1111;
        wdata_c    = readData2;
      end
      default: ;
    endcase
    is_mem_c = is_load_c | is_store_c;
  end

`ifdef MEM_ALIGN_EXC_EN
  always_comb begin
    align_fault_c = 1'b0;
    if (inst_name == OP_LH || inst_name == OP_LHU || inst_name == OP_SH)
      align_fault_c = aluResult[0];
    else if (inst_name == OP_LW || inst_name == OP_SW)
      align_fault_c = |aluResult[1:0];
  end

  // Exception pulse; faulting address held until the next fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_exc  <= 1'b0;
      bad_vaddr <= 32'h0;
    end else begin
      addr_exc <= accept_c && is_mem_c && align_fault_c;
      if (accept_c && is_mem_c && align_fault_c)
        bad_vaddr <= aluResult;
    end
  end
`else
  assign align_fault_c = 1'b0;
  assign addr_exc      = 1'b0;
  assign bad_vaddr     = 32'h0;
`endif

  function automatic logic [31:0] load_result(input logic [7:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = off[1] ? rd[31:16] : rd[15:0];
    if (op == OP_LB)       return {{24{b[7]}}, b};
    else if (op == OP_LBU) return {24'h0, b};
    else if (op == OP_LH)  return {{16{h[15]}}, h};
    else if (op == OP_LHU) return {16'h0, h};
    else                   return rd;
  endfunction

  // Transaction FSM with registered bus and writeback outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      op_q       <= 8'h0;
      off_q      <= 2'b00;
      reg_q      <= 5'd0;
      flushed_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_reg     <= 5'd0;
      wb_data    <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      bus_err  <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_reg   <= 5'd0;
      wb_data  <= 32'h0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (!is_mem_c) begin
              wb_valid <= 1'b1;
              wb_we    <= (writeDataReg != 5'd0);
              wb_reg   <= writeDataReg;
              wb_data  <= aluResult;
            end else if (!align_fault_c) begin
              state      <= BUSY;
              cnt_q      <= '0;
              op_q       <= inst_name;
              off_q      <= aluResult[1:0];
              reg_q      <= writeDataReg;
              flushed_q  <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store_c;
              dmem_addr  <= {aluResult[31:2], 2'b00};
              dmem_be    <= be_c;
              dmem_wdata <= wdata_c;
            end
          end
        end
        BUSY: begin
          if (flush)
            flushed_q <= 1'b1;
          if (dmem_ack || cnt_q == CNT_LAST) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
          end
          // A completing ack takes priority over the timeout
          if (dmem_ack) begin
            if (!(flushed_q || flush)) begin
              wb_valid <= 1'b1;
              wb_we    <= !dmem_we && (reg_q != 5'd0);
              wb_reg   <= reg_q;
              wb_data  <= dmem_we ? 32'h0 : load_result(op_q, off_q, dmem_rdata);
            end
          end else if (cnt_q == CNT_LAST) begin
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
// Honours MEM_ALIGN_EXC_EN the same way the design does.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0] OP_LB  = 8'd20;
  localparam logic [7:0] OP_LBU = 8'd21;
  localparam logic [7:0] OP_LH  = 8'd22;
  localparam logic [7:0] OP_LHU = 8'd23;
  localparam logic [7:0] OP_LW  = 8'd24;
  localparam logic [7:0] OP_SB  = 8'd25;
  localparam logic [7:0] OP_SH  = 8'd26;
  localparam logic [7:0] OP_SW  = 8'd27;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, flush, dmem_ack;
  logic [7:0]  inst_name;
  logic [31:0] aluResult, readData2, dmem_rdata;
  logic [4:0]  writeDataReg;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_we, bus_err, addr_exc;
  logic [31:0] dmem_addr, dmem_wdata, wb_data, bad_vaddr;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_reg;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .inst_name(inst_name),
    .aluResult(aluResult), .readData2(readData2), .writeDataReg(writeDataReg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .bus_err(bus_err), .addr_exc(addr_exc), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wdata_chk;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wbd_chk;
    logic        bus_err;
    logic        addr_exc;
    logic [31:0] bad_vaddr;
  } exp_t;

  exp_t        ex;
  bit          cmp_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] bad_model = 32'h0;

  int          stall_cycles;
  logic        first_req, first_we, last_wb_valid, last_wb_we, last_bus_err, last_req, last_stall;
  logic        last_addr_exc;
  logic [31:0] first_addr, first_wdata, last_wb_data, last_bad;
  logic [3:0]  first_be;
  logic [4:0]  last_wb_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Reference rules
  function automatic bit m_is_mem(input logic [7:0] op);
    return op >= OP_LB && op <= OP_SW;
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return op >= OP_SB && op <= OP_SW;
  endfunction

  function automatic int m_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic int m_lane(input int sz, input logic [31:0] a);
    if (sz == 4) return 0;
    if (sz == 2) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [31:0] m_mask(input int sz);
    return (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 64'd1);
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input int lo, input int sz,
                                         input logic [31:0] rdv);
    logic [31:0] mask, v;
    mask = m_mask(sz);
    v = (rdv >> (8 * lo)) & mask;
    if ((op == OP_LB || op == OP_LH) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.bad_vaddr = bad_model;
    return e;
  endfunction

  // Every-cycle compare of DUT outputs against the model expectation
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 32'(stall), 32'(ex.stall));
      chk("dmem_req", 32'(dmem_req), 32'(ex.req));
      chk("bus_err", 32'(bus_err), 32'(ex.bus_err));
      chk("wb_valid", 32'(wb_valid), 32'(ex.wb_valid));
      chk("wb_we", 32'(wb_we), 32'(ex.wb_we));
      chk("addr_exc", 32'(addr_exc), 32'(ex.addr_exc));
      chk("bad_vaddr", bad_vaddr, ex.bad_vaddr);
      if (ex.req) begin
        chk("dmem_we", 32'(dmem_we), 32'(ex.we));
        chk("dmem_addr", dmem_addr, ex.addr);
        chk("dmem_be", 32'(dmem_be), 32'(ex.be));
      end
      if (ex.wdata_chk) chk("dmem_wdata", dmem_wdata, ex.wdata);
      if (ex.wbd_chk) begin
        chk("wb_reg", 32'(wb_reg), 32'(ex.wb_reg));
        chk("wb_data", wb_data, ex.wb_data);
      end
    end
  end

  task automatic tick(input exp_t e);
    @(posedge clk);
    #1;
    ex = e;
  endtask

  task automatic rand_slot();
    in_valid     = 1'($urandom);
    inst_name    = 8'($urandom);
    aluResult    = $urandom;
    readData2    = $urandom;
    writeDataReg = 5'($urandom);
  endtask

  // Non-accepted or non-memory slot; one cycle
  task automatic alu_op(input logic [7:0] op, input logic v, input logic f,
                        input logic [31:0] a, input logic [4:0] rd, input logic ack);
    exp_t e;
    in_valid = v; flush = f; inst_name = op; aluResult = a; readData2 = $urandom;
    writeDataReg = rd; dmem_ack = ack; dmem_rdata = $urandom;
    e = idle_exp();
    if (v && !f && !m_is_mem(op)) begin
      e.wb_valid = 1'b1; e.wb_we = (rd != 5'd0); e.wb_reg = rd; e.wb_data = a; e.wbd_chk = 1'b1;
    end
    tick(e);
    dmem_ack = 1'b0;
  endtask

  // Accepted memory op; delay = ack cycle (0 or > TIMEOUT: never), flush_at < 0: random flushes
  task automatic mem_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input int delay, input int flush_at,
                        input bit rd_fixed, input logic [31:0] rd_val);
    exp_t        e;
    int          sz, lo;
    bit          st, flushed;
    logic [31:0] rdv;
    sz = m_size(op); lo = m_lane(sz, a); st = m_is_store(op); flushed = 1'b0;
    in_valid = 1'b1; flush = 1'b0; inst_name = op; aluResult = a; readData2 = d;
    writeDataReg = rd; dmem_ack = 1'b0;
    stall_cycles = 0;
`ifdef MEM_ALIGN_EXC_EN
    if ((a & 32'(sz - 1)) != 32'h0) begin
      bad_model = a;
      e = idle_exp();
      e.addr_exc = 1'b1;
      tick(e);
      first_req = dmem_req; last_addr_exc = addr_exc; last_bad = bad_vaddr;
      return;
    end
`endif
    e = idle_exp();
    e.stall = 1'b1; e.req = 1'b1; e.we = st; e.addr = a & ~32'h3;
    e.be = 4'(((1 << sz) - 1) << lo);
    e.wdata = st ? m_wdata(sz, d) : 32'h0; e.wdata_chk = st;
    tick(e);
    first_req = dmem_req; first_we = dmem_we; first_addr = dmem_addr;
    first_be = dmem_be; first_wdata = dmem_wdata;
    stall_cycles += int'(stall);
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      rdv = rd_fixed ? rd_val : $urandom;
      dmem_rdata = rdv;
      dmem_ack = (k == delay);
      rand_slot();
      flush = (flush_at < 0) ? ($urandom_range(0, 7) == 0) : (k == flush_at);
      if (flush) flushed = 1'b1;
      if (k == delay) begin
        e = idle_exp();
        if (!flushed) begin
          e.wb_valid = 1'b1; e.wb_we = !st && (rd != 5'd0);
          e.wb_reg = rd; e.wb_data = m_load(op, lo, sz, rdv); e.wbd_chk = !st;
        end
      end else if (k == int'(TIMEOUT)) begin
        e = idle_exp();
        e.bus_err = 1'b1;
      end
      tick(e);
      stall_cycles += int'(stall);
      if (!e.stall) break;
    end
    last_wb_valid = wb_valid; last_wb_we = wb_we; last_wb_reg = wb_reg; last_wb_data = wb_data;
    last_bus_err = bus_err; last_req = dmem_req; last_stall = stall;
    dmem_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic reset_mid_busy();
    exp_t e;
    in_valid = 1'b1; flush = 1'b0; inst_name = OP_LW; aluResult = 32'h0000_0400;
    readData2 = 32'h0; writeDataReg = 5'd3; dmem_ack = 1'b0;
    e = idle_exp();
    e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h0000_0400; e.be = 4'hF;
    tick(e);
    rand_slot();
    tick(e);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    bad_model = 32'h0;
    ex = idle_exp();
    tick(idle_exp());
    dmem_ack = 1'b1;
    tick(idle_exp());
    rst = 1'b1;
    alu_op(OP_LW, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1);
    alu_op(8'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [7:0]  op;
    logic        v, f;
    int          r, dly;
    in_valid = 1'b0; flush = 1'b0; inst_name = 8'h0; aluResult = 32'h0; readData2 = 32'h0;
    writeDataReg = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_bad_vaddr", bad_vaddr, 32'h0);
    ex = idle_exp();
    cmp_en = 1'b1;
    rst = 1'b1;

    alu_op(8'd3, 1'b1, 1'b0, 32'hCAFE_0001, 5'd9, 1'b0);
    alu_op(8'd3, 1'b1, 1'b0, 32'h1234_5678, 5'd0, 1'b1);

    mem_op(OP_LW, 32'h100, 32'h0, 5'd7, 4, 0, 1'b1, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("lw_addr", first_addr, 32'h100);
    chk("lw_be", 32'(first_be), 32'hF);
    chk("lw_data", last_wb_data, 32'hDEAD_BEEF);
    chk("lw_reg", 32'(last_wb_reg), 32'd7);

    mem_op(OP_LB, 32'h103, 32'h0, 5'd1, 2, 0, 1'b1, 32'h80FF_0000);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    mem_op(OP_LBU, 32'h103, 32'h0, 5'd1, 1, 0, 1'b1, 32'h80FF_0000);
    chk("lbu_data", last_wb_data, 32'h0000_0080);
    mem_op(OP_LH, 32'h102, 32'h0, 5'd2, 3, 0, 1'b1, 32'h80FF_0000);
    chk("lh_data", last_wb_data, 32'hFFFF_80FF);

    mem_op(OP_SB, 32'h201, 32'h1234_5678, 5'd4, 2, 0, 1'b0, 32'h0);
    chk("sb_be", 32'(first_be), 32'h2);
    chk("sb_wdata", first_wdata, 32'h7878_7878);
    chk("sb_we", 32'(first_we), 32'd1);
    chk("sb_wb_valid", 32'(last_wb_valid), 32'd1);
    chk("sb_wb_we", 32'(last_wb_we), 32'd0);

    mem_op(OP_LW, 32'h500, 32'h0, 5'd6, 0, 0, 1'b0, 32'h0);
    chk("to_bus_err", 32'(last_bus_err), 32'd1);
    chk("to_req", 32'(last_req), 32'd0);
    chk("to_stall", 32'(last_stall), 32'd0);
    chk("to_wb_valid", 32'(last_wb_valid), 32'd0);

    mem_op(OP_LHU, 32'h600, 32'h0, 5'd8, int'(TIMEOUT), 0, 1'b1, 32'h0000_9ABC);
    chk("ack_at_limit", 32'(last_wb_valid), 32'd1);

    mem_op(OP_LW, 32'h104, 32'h0, 5'd5, 3, 1, 1'b0, 32'h0);
    chk("flush_wb_valid", 32'(last_wb_valid), 32'd0);

    mem_op(OP_SW, 32'h302, 32'hAABB_CCDD, 5'd0, 2, 0, 1'b0, 32'h0);
`ifdef MEM_ALIGN_EXC_EN
    chk("sw_mis_req", 32'(first_req), 32'd0);
    chk("sw_mis_exc", 32'(last_addr_exc), 32'd1);
    chk("sw_mis_bad", last_bad, 32'h302);
`else
    chk("sw_mis_addr", first_addr, 32'h300);
    chk("sw_mis_be", 32'(first_be), 32'hF);
`endif

    reset_mid_busy();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) op = 8'($urandom_range(20, 27));
      else op = 8'($urandom_range(0, 255));
      v = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      if (r < 14) dly = 1 + (r % 4);
      else if (r < 16) dly = int'(TIMEOUT);
      else if (r < 17) dly = 0;
      else dly = $urandom_range(5, int'(TIMEOUT) - 1);
      if (m_is_mem(op) && v && !f)
        mem_op(op, $urandom, $urandom, 5'($urandom), dly, -1, 1'b0, 32'h0);
      else
        alu_op(op, v, f, $urandom, 5'($urandom), 1'($urandom));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
